slave_out_port: RTL

Slave-side read-data transmitter for the serial system bus. On a read request it fetches parallel words from the slave's local memory and serializes them LSB-first on tx_data, qualified by slave_valid and throttled by master_ready. It is the counterpart of the master's serial receive port. It supports single and burst reads and flags completion to the slave controller with tx_done.

---
 rtl/slave_out_port.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/slave_out_port.sv
// slave_out_port: slave-side serial read-data transmitter.
// Fetches parallel words from local memory and shifts them out LSB-first
// on tx_data, qualified by slave_valid and throttled by master_ready.
// A bit is consumed on every rising edge where slave_valid and master_ready
// are both high. All outputs come straight from flops.
module slave_out_port #(
  parameter int burst_len = 12,
  parameter int data_len  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           instruction,
  input  logic [burst_len-1:0] burst_num,
  input  logic [data_len-1:0]  data,
  input  logic                 data_valid,
  output logic                 data_req,
  output logic                 tx_data,
  output logic                 slave_valid,
  input  logic                 master_ready,
  output logic                 tx_done,
  output logic                 busy
);

  localparam int CW = $clog2(data_len + 1);
  localparam logic [1:0] INSTR_READ = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_RDY,
    SEND,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [burst_len-1:0] words_left_q, words_left_d;
  logic [data_len-1:0]  shift_q, shift_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 data_req_q, data_req_d;
  logic                 tx_data_q, tx_data_d;
  logic                 slave_valid_q, slave_valid_d;
  logic                 tx_done_q, tx_done_d;
  logic                 busy_q, busy_d;

  // Next-state, datapath and registered-output computation.
  // SEND spends its first cycle presenting shift[0]; from then on each
  // accepted bit advances the shifter and the next bit is presented.
  always_comb begin
    state_d       = state_q;
    words_left_d  = words_left_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    slave_valid_d = 1'b0;
    tx_data_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && instruction == INSTR_READ) begin
          words_left_d = (burst_num == '0) ? burst_len'(1) : burst_num;
          state_d      = FETCH;
        end
      end
      FETCH: begin
        if (data_valid) begin
          shift_d   = data;
          bit_cnt_d = '0;
          state_d   = master_ready ? SEND : WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (master_ready) state_d = SEND;
      end
      SEND: begin
        if (!slave_valid_q) begin
          slave_valid_d = 1'b1;
          tx_data_d     = shift_q[0];
        end else if (master_ready) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CW'(data_len - 1)) begin
            // last bit of this word accepted: drop valid for the gap
            if (words_left_q > burst_len'(1)) begin
              words_left_d = words_left_q - 1'b1;
              state_d      = FETCH;
            end else begin
              state_d = DONE;
            end
          end else begin
            slave_valid_d = 1'b1;
            tx_data_d     = shift_q[1];
          end
        end else begin
          // stall: keep presenting the same bit
          slave_valid_d = 1'b1;
          tx_data_d     = tx_data_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    data_req_d = (state_d == FETCH);
    tx_done_d  = (state_d == DONE);
    busy_d     = (state_d != IDLE);
  end

  // State and output registers with synchronous reset (aborts any transfer).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      words_left_q  <= '0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      data_req_q    <= 1'b0;
      tx_data_q     <= 1'b0;
      slave_valid_q <= 1'b0;
      tx_done_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      words_left_q  <= words_left_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      data_req_q    <= data_req_d;
      tx_data_q     <= tx_data_d;
      slave_valid_q <= slave_valid_d;
      tx_done_q     <= tx_done_d;
      busy_q        <= busy_d;
    end
  end

  assign data_req    = data_req_q;
  assign tx_data     = tx_data_q;
  assign slave_valid = slave_valid_q;
  assign tx_done     = tx_done_q;
  assign busy        = busy_q;

endmodule
